aes_round_sched: RTL and testbench
==================================

Name: aes_round_sched

Overview:
- Round sequencer for the AES-128 cipher core.
- Accepts a block-start request and drives the key-expansion unit with a load strobe followed by one step strobe per round, carrying the matching rcon byte.
- Drives the round datapath selects for the initial AddRoundKey, middle rounds and the final round (no MixColumns).
- Presents completion via a valid/ready hold handshake; sits between the block I/O wrapper and the round/key-expansion datapath.

Parameters:
- NR, 10, number of cipher rounds; legal range 2..10 (rcon table covers 10 steps).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst  input  1  synchronous active-low reset.
- start  input  1  block-start request; accepted only when start && ready.
- ready  output  1  high only in IDLE with rst high.
- abort  input  1  synchronous abort; wins over every other input except rst.
- kld  output  1  key-expansion load strobe (copy input key).
- key_step  output  1  key-expansion advance strobe.
- rcon  output  8  round constant, valid when key_step=1, else 8'h00.
- round  output  4  current round index, 0..NR.
- sel_init  output  1  datapath performs initial AddRoundKey only.
- sel_final  output  1  datapath skips MixColumns.
- busy  output  1  high in LOAD, INIT, ROUND and FINAL.
- out_valid  output  1  result available; held until out_ready.
- out_ready  input  1  consumer accepts result.
- blk_cnt  output  CNT_W  number of completed blocks, saturating.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE; all registered outputs go to 0 (round=0, rcon=8'h00, blk_cnt=0).
  - ready=0 while rst=0. Reset mid-block discards the block with no out_valid.
- States and transitions: IDLE -> LOAD -> INIT -> ROUND -> FINAL -> HOLD -> IDLE.
- IDLE: ready=1. start=1 moves to LOAD at the next edge.
- LOAD, 1 cycle: kld=1, round=0.
- INIT, 1 cycle: sel_init=1, round=0.
- ROUND, NR-1 cycles: round=1..NR-1, incrementing each cycle; key_step=1.
- FINAL, 1 cycle: round=NR, key_step=1, sel_final=1.
- HOLD: out_valid=1, round=NR. out_valid && out_ready moves to IDLE and increments blk_cnt.
- blk_cnt saturates at all-ones.
- Outputs are registered and decoded from state/round. Every strobe is 1 only in its listed state and 0 elsewhere.
- Latency: if start is sampled at edge 0, state is LOAD in cycle 1, INIT in cycle 2, ROUND in cycles 3..NR+1, FINAL in cycle NR+2, and out_valid first goes high in cycle NR+3 (cycle 13 for NR=10).
- rcon generation:
  - rcon register is 8'h01 at LOAD.
  - It is output during key_step cycles.
  - After each key_step it is updated by xtime: shift left 1, XOR 8'h1b if bit7 was 1.
  - Sequence for NR=10: 01,02,04,08,10,20,40,80,1b,36.
  - rcon is 8'h00 whenever key_step=0.
- Round counter: 4-bit, no wrap; never exceeds NR.
- start while not IDLE: ignored, with no queuing. ready=0, so there is no back-to-back acceptance in HOLD.
- start and out_ready in the same HOLD cycle: the handshake completes, start is ignored, and the state is IDLE next cycle.
- abort=1 in any state: next state IDLE with all strobes and out_valid 0. blk_cnt is unchanged. A pending result in HOLD is dropped.
- abort and start together in IDLE: abort wins and the state stays IDLE.
- out_ready while out_valid=0 has no effect.
- Exactly one of kld, sel_init, key_step, out_valid may be high in a cycle, except FINAL where key_step and sel_final are both high.

Test Plan:
- Nominal block, NR=10: reset, then start=1 for 1 cycle, out_ready=1 -> kld in cycle 1, sel_init in cycle 2, key_step in cycles 3..12, rcon 01,02,04,08,10,20,40,80,1b,36, sel_final in cycle 12 only, out_valid in cycle 13 for 1 cycle, blk_cnt=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid held 6 cycles, round=10 throughout, start pulses ignored; out_ready=1 -> IDLE, blk_cnt increments by exactly 1.
- Abort during round 5: abort=1 in ROUND with round=5 -> next cycle IDLE, ready=1, no out_valid, blk_cnt unchanged; a following start gives a full 13-cycle block with rcon restarting at 01.
- Reset mid-operation: rst=0 in cycle 7 -> all outputs 0 next cycle, ready=0 while rst=0, ready=1 after release; no out_valid.
- Parameter NR=2: start -> LOAD, INIT, ROUND round=1 rcon=01, FINAL round=2 rcon=02 sel_final=1, out_valid in cycle 5.
- Counter saturation: CNT_W=2, 5 completed blocks -> blk_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/aes_round_sched.sv
// AES-128 round sequencer: drives key-expansion strobes with rcon, round-datapath
// selects, and a held valid/ready completion handshake with a saturating block counter.
module aes_round_sched #(
    parameter int NR    = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic             abort,
    output logic             kld,
    output logic             key_step,
    output logic [7:0]       rcon,
    output logic [3:0]       round,
    output logic             sel_init,
    output logic             sel_final,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [2:0] {IDLE, LOAD, INIT, ROUND, FINAL, HOLD} state_t;

    localparam logic [3:0] NR_L  = 4'(NR);
    localparam logic [3:0] NR_M1 = 4'(NR - 1);

    // GF(2^8) multiply-by-x used to advance the round constant
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t           state_r, state_nx_s;
    logic [3:0]       round_r, round_nx_s;
    logic [7:0]       rcon_acc_r, rcon_acc_nx_s;
    logic             cnt_inc_s;
    logic             key_step_nx_s;
    logic             ready_r, kld_r, key_step_r, sel_init_r, sel_final_r, busy_r, out_valid_r;
    logic [7:0]       rcon_r;
    logic [CNT_W-1:0] blk_cnt_r;

    // Next-state, round index and rcon accumulator; abort overrides everything but rst
    always_comb begin
        state_nx_s    = state_r;
        round_nx_s    = round_r;
        rcon_acc_nx_s = rcon_acc_r;
        cnt_inc_s     = 1'b0;
        if (abort) begin
            state_nx_s = IDLE;
            round_nx_s = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    round_nx_s = 4'd0;
                    if (start) begin
                        state_nx_s    = LOAD;
                        rcon_acc_nx_s = 8'h01;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                LOAD: begin
                    state_nx_s = INIT;
                    round_nx_s = 4'd0;
                end
                INIT: begin
                    state_nx_s    = ROUND;
                    round_nx_s    = 4'd1;
                    rcon_acc_nx_s = xtime(rcon_acc_r);
                end
                ROUND: begin
                    rcon_acc_nx_s = xtime(rcon_acc_r);
                    if (round_r == NR_M1) begin
                        state_nx_s = FINAL;
                        round_nx_s = NR_L;
                    end else begin
                        state_nx_s = ROUND;
                        round_nx_s = round_r + 4'd1;
                    end
                end
                FINAL: begin
                    state_nx_s = HOLD;
                    round_nx_s = NR_L;
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nx_s = IDLE;
                        round_nx_s = 4'd0;
                        cnt_inc_s  = 1'b1;
                    end else begin
                        state_nx_s = HOLD;
                        round_nx_s = NR_L;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    round_nx_s = 4'd0;
                end
            endcase
        end
    end

    assign key_step_nx_s = (state_nx_s == ROUND) || (state_nx_s == FINAL);

    // State and registered outputs, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            round_r     <= 4'd0;
            rcon_acc_r  <= 8'h00;
            rcon_r      <= 8'h00;
            ready_r     <= 1'b0;
            kld_r       <= 1'b0;
            key_step_r  <= 1'b0;
            sel_init_r  <= 1'b0;
            sel_final_r <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            blk_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            round_r     <= round_nx_s;
            rcon_acc_r  <= rcon_acc_nx_s;
            rcon_r      <= key_step_nx_s ? rcon_acc_r : 8'h00;
            ready_r     <= (state_nx_s == IDLE);
            kld_r       <= (state_nx_s == LOAD);
            key_step_r  <= key_step_nx_s;
            sel_init_r  <= (state_nx_s == INIT);
            sel_final_r <= (state_nx_s == FINAL);
            busy_r      <= (state_nx_s == LOAD) || (state_nx_s == INIT) || key_step_nx_s;
            out_valid_r <= (state_nx_s == HOLD);
            if (cnt_inc_s && (blk_cnt_r != {CNT_W{1'b1}})) begin
                blk_cnt_r <= blk_cnt_r + CNT_W'(1);
            end else begin
                blk_cnt_r <= blk_cnt_r;
            end
        end
    end

    assign ready     = ready_r;
    assign kld       = kld_r;
    assign key_step  = key_step_r;
    assign rcon      = rcon_r;
    assign round     = round_r;
    assign sel_init  = sel_init_r;
    assign sel_final = sel_final_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign blk_cnt   = blk_cnt_r;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: NR=10/CNT_W=16 instance plus an NR=2/CNT_W=2 instance.
module tb_aes_round_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic start2 = 1'b0, abort2 = 1'b0, out_ready2 = 1'b0;

    logic        ready, kld, key_step, sel_init, sel_final, busy, out_valid;
    logic [7:0]  rcon;
    logic [3:0]  round;
    logic [15:0] blk_cnt;

    logic        ready2, kld2, key_step2, sel_init2, sel_final2, busy2, out_valid2;
    logic [7:0]  rcon2;
    logic [3:0]  round2;
    logic [1:0]  blk_cnt2;

    int checks = 0;
    int errors = 0;

    logic [7:0] rc_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    aes_round_sched #(.NR(10), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .abort(abort),
        .kld(kld), .key_step(key_step), .rcon(rcon), .round(round),
        .sel_init(sel_init), .sel_final(sel_final), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .blk_cnt(blk_cnt)
    );

    aes_round_sched #(.NR(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .ready(ready2), .abort(abort2),
        .kld(kld2), .key_step(key_step2), .rcon(rcon2), .round(round2),
        .sel_init(sel_init2), .sel_final(sel_final2), .busy(busy2),
        .out_valid(out_valid2), .out_ready(out_ready2), .blk_cnt(blk_cnt2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", ready); end
        checks++; if ({kld, key_step, sel_init, sel_final, busy, out_valid} !== 6'b0) begin errors++; $display("FAIL rst_strobes got %b exp 000000", {kld, key_step, sel_init, sel_final, busy, out_valid}); end
        checks++; if (round !== 4'd0 || rcon !== 8'h00) begin errors++; $display("FAIL rst_round_rcon got %0d/%h exp 0/00", round, rcon); end
        checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL rst_blk_cnt got %0d exp 0", blk_cnt); end
        rst = 1'b1;
        step();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b exp 1", ready); end
    endtask

    task automatic test_nominal();
        logic [3:0] er;
        logic [7:0] erc;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            er  = (c <= 2) ? 4'd0 : ((c <= 11) ? 4'(c - 2) : 4'd10);
            erc = (c >= 3 && c <= 12) ? rc_tab[c-3] : 8'h00;
            checks++; if (kld !== (c == 1)) begin errors++; $display("FAIL nom_kld c%0d got %0b", c, kld); end
            checks++; if (sel_init !== (c == 2)) begin errors++; $display("FAIL nom_sel_init c%0d got %0b", c, sel_init); end
            checks++; if (key_step !== (c >= 3 && c <= 12)) begin errors++; $display("FAIL nom_key_step c%0d got %0b", c, key_step); end
            checks++; if (sel_final !== (c == 12)) begin errors++; $display("FAIL nom_sel_final c%0d got %0b", c, sel_final); end
            checks++; if (out_valid !== (c == 13)) begin errors++; $display("FAIL nom_out_valid c%0d got %0b", c, out_valid); end
            checks++; if (busy !== (c <= 12)) begin errors++; $display("FAIL nom_busy c%0d got %0b", c, busy); end
            checks++; if (round !== er) begin errors++; $display("FAIL nom_round c%0d got %0d exp %0d", c, round, er); end
            checks++; if (rcon !== erc) begin errors++; $display("FAIL nom_rcon c%0d got %h exp %h", c, rcon, erc); end
            step();
        end
        checks++; if (out_valid !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL nom_end got ov=%0b rdy=%0b exp 0/1", out_valid, ready); end
        checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL nom_blk_cnt got %0d exp 1", blk_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        for (int i = 0; i < 6; i++) begin
            checks++; if (out_valid !== 1'b1 || round !== 4'd10) begin errors++; $display("FAIL bp_hold i%0d got ov=%0b rnd=%0d exp 1/10", i, out_valid, round); end
            checks++; if (ready !== 1'b0 || kld !== 1'b0) begin errors++; $display("FAIL bp_ignore_start i%0d got rdy=%0b kld=%0b exp 0/0", i, ready, kld); end
            start = 1'b1;
            out_ready = (i == 5);
            step();
        end
        start = 1'b0;
        checks++; if (out_valid !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle got ov=%0b rdy=%0b busy=%0b exp 0/1/0", out_valid, ready, busy); end
        checks++; if (blk_cnt !== 16'd2) begin errors++; $display("FAIL bp_blk_cnt got %0d exp 2", blk_cnt); end
        step();
        checks++; if (kld !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL bp_no_queue got kld=%0b rdy=%0b exp 0/1", kld, ready); end
    endtask

    task automatic test_abort();
        logic ov_seen;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        checks++; if (round !== 4'd5 || key_step !== 1'b1) begin errors++; $display("FAIL ab_pre got rnd=%0d ks=%0b exp 5/1", round, key_step); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (ready !== 1'b1 || out_valid !== 1'b0 || key_step !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ab_idle got rdy=%0b ov=%0b ks=%0b busy=%0b exp 1/0/0/0", ready, out_valid, key_step, busy); end
        checks++; if (round !== 4'd0 || rcon !== 8'h00) begin errors++; $display("FAIL ab_round_rcon got %0d/%h exp 0/00", round, rcon); end
        checks++; if (blk_cnt !== 16'd2) begin errors++; $display("FAIL ab_blk_cnt got %0d exp 2", blk_cnt); end
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        checks++; if (kld !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL ab_start_lose got kld=%0b rdy=%0b exp 0/1", kld, ready); end
        start = 1'b1;
        step();
        start = 1'b0;
        ov_seen = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (c >= 3 && c <= 12) begin
                checks++; if (rcon !== rc_tab[c-3]) begin errors++; $display("FAIL ab_rerun_rcon c%0d got %h exp %h", c, rcon, rc_tab[c-3]); end
            end
            if (c == 13) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ab_rerun_ov got %0b exp 1", out_valid); end
            end else begin
                ov_seen = ov_seen | out_valid;
            end
            step();
        end
        checks++; if (ov_seen !== 1'b0) begin errors++; $display("FAIL ab_rerun_early_ov got %0b exp 0", ov_seen); end
        checks++; if (blk_cnt !== 16'd3) begin errors++; $display("FAIL ab_rerun_blk_cnt got %0d exp 3", blk_cnt); end
    endtask

    task automatic test_reset_mid();
        logic ov_seen;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        rst = 1'b0;
        step();
        checks++; if ({ready, kld, key_step, sel_init, sel_final, busy, out_valid} !== 7'b0) begin errors++; $display("FAIL rm_strobes got %b exp 0000000", {ready, kld, key_step, sel_init, sel_final, busy, out_valid}); end
        checks++; if (round !== 4'd0 || rcon !== 8'h00 || blk_cnt !== 16'd0) begin errors++; $display("FAIL rm_regs got %0d/%h/%0d exp 0/00/0", round, rcon, blk_cnt); end
        step();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rm_ready_low got %0b exp 0", ready); end
        rst = 1'b1;
        step();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rm_ready_release got %0b exp 1", ready); end
        ov_seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            ov_seen = ov_seen | out_valid;
            step();
        end
        checks++; if (ov_seen !== 1'b0) begin errors++; $display("FAIL rm_no_ov got %0b exp 0", ov_seen); end
    endtask

    task automatic test_nr2();
        out_ready2 = 1'b1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        checks++; if (kld2 !== 1'b1 || round2 !== 4'd0) begin errors++; $display("FAIL nr2_load got kld=%0b rnd=%0d exp 1/0", kld2, round2); end
        step();
        checks++; if (sel_init2 !== 1'b1 || kld2 !== 1'b0) begin errors++; $display("FAIL nr2_init got si=%0b kld=%0b exp 1/0", sel_init2, kld2); end
        step();
        checks++; if (key_step2 !== 1'b1 || round2 !== 4'd1 || rcon2 !== 8'h01 || sel_final2 !== 1'b0) begin errors++; $display("FAIL nr2_round got ks=%0b rnd=%0d rc=%h sf=%0b exp 1/1/01/0", key_step2, round2, rcon2, sel_final2); end
        step();
        checks++; if (key_step2 !== 1'b1 || round2 !== 4'd2 || rcon2 !== 8'h02 || sel_final2 !== 1'b1) begin errors++; $display("FAIL nr2_final got ks=%0b rnd=%0d rc=%h sf=%0b exp 1/2/02/1", key_step2, round2, rcon2, sel_final2); end
        step();
        checks++; if (out_valid2 !== 1'b1 || round2 !== 4'd2 || key_step2 !== 1'b0 || rcon2 !== 8'h00) begin errors++; $display("FAIL nr2_hold got ov=%0b rnd=%0d ks=%0b rc=%h exp 1/2/0/00", out_valid2, round2, key_step2, rcon2); end
        step();
        checks++; if (blk_cnt2 !== 2'd1 || out_valid2 !== 1'b0) begin errors++; $display("FAIL nr2_done got cnt=%0d ov=%0b exp 1/0", blk_cnt2, out_valid2); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        out_ready2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start2 = 1'b1;
            step();
            start2 = 1'b0;
            repeat (5) step();
            exp_cnt = (i == 0) ? 2'd2 : 2'd3;
            checks++; if (blk_cnt2 !== exp_cnt) begin errors++; $display("FAIL sat_blk_cnt blk%0d got %0d exp %0d", i + 2, blk_cnt2, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_nr2();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
